// File: rtl/motor_spi_master.sv
// SPI initiator for the two-byte motor command link: shifts {motor1, motor2} out MSB first
// under a whole-frame load strobe and captures the 16 bits returned on sdi.
module motor_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NBITS   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       motor1,
    input  logic [7:0]       motor2,
    input  logic             sdi,
    output logic             sck,
    output logic             sdo,
    output logic             load,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] rx_data
);

    localparam int unsigned CntW    = $clog2(NBITS + 1);
    localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
    localparam logic [CntW-1:0] LastBit = CntW'(NBITS);

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold} state_e;

    state_e           state;
    logic [7:0]       div_cnt;
    logic [CntW-1:0]  bit_cnt;
    logic [NBITS-1:0] tx_shift;
    logic [NBITS-1:0] rx_shift;
    logic             div_last;

    assign div_last = (div_cnt == DivLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            div_cnt  <= 8'd0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            sck      <= 1'b0;
            sdo      <= 1'b0;
            load     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    div_cnt <= 8'd0;
                    if (start) begin
                        tx_shift <= {motor1, motor2};
                        sdo      <= motor1[7];
                        load     <= 1'b1;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= StSetup;
                    end
                end
                // Both phases end by raising sck and sampling sdi on that same edge.
                StSetup, StLow: begin
                    if (div_last) begin
                        div_cnt  <= 8'd0;
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[NBITS-2:0], sdi};
                        bit_cnt  <= bit_cnt + CntW'(1);
                        state    <= StHigh;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                StHigh: begin
                    if (div_last) begin
                        div_cnt <= 8'd0;
                        sck     <= 1'b0;
                        if (bit_cnt != LastBit) begin
                            tx_shift <= {tx_shift[NBITS-2:0], 1'b0};
                            sdo      <= tx_shift[NBITS-2];
                            state    <= StLow;
                        end else begin
                            state <= StHold;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                StHold: begin
                    if (div_last) begin
                        div_cnt <= 8'd0;
                        load    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sdo     <= 1'b0;
                        rx_data <= rx_shift;
                        state   <= StIdle;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_spi_master.sv
// Bench for motor_spi_master: vector table of frames at CLK_DIV=4 with an sdo/rx scoreboard,
// plus hand-written sequences for mid-frame start, mid-frame reset and CLK_DIV=1 back-to-back.
module tb_motor_spi_master;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // CLK_DIV=4 instance
    logic        start, sdi, sdi_val, loop;
    logic [7:0]  motor1, motor2;
    logic        sck, sdo, load, busy, done;
    logic [15:0] rx_data;
    assign sdi = loop ? sdo : sdi_val;

    // CLK_DIV=1 instance
    logic        start1, sdi1;
    logic        sck1, sdo1, load1, busy1, done1;
    logic [15:0] rx_data1;

    motor_spi_master #(.CLK_DIV(4), .NBITS(16)) dut4 (
        .clk(clk), .reset(reset), .start(start), .motor1(motor1), .motor2(motor2),
        .sdi(sdi), .sck(sck), .sdo(sdo), .load(load), .busy(busy), .done(done),
        .rx_data(rx_data)
    );

    motor_spi_master #(.CLK_DIV(1), .NBITS(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .motor1(8'hC3), .motor2(8'h5A),
        .sdi(sdi1), .sck(sck1), .sdo(sdo1), .load(load1), .busy(busy1), .done(done1),
        .rx_data(rx_data1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic        exp_bits[$];
    logic [15:0] exp_rx_q[$];
    int          rises    = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for dut4, sampling on the falling clk edge.
    initial begin
        logic sck_prev  = 1'b0;
        logic load_prev = 1'b0;
        int   load_len  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sck_prev  = 1'b0;
                load_prev = 1'b0;
                load_len  = 0;
                rises     = 0;
            end else begin
                if (sck && !sck_prev) begin
                    rises++;
                    if (exp_bits.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL sck_rise: got unexpected rise %0d, expected none", rises);
                    end else begin
                        check("sdo_at_sck_rise", sdo, exp_bits.pop_front());
                    end
                end
                if (load) load_len++;
                else if (load_prev) begin
                    check("load_high_cycles", load_len, 132);
                    load_len = 0;
                end
                if (done) begin
                    done_cnt++;
                    check("sck_rises_per_frame", rises, 16);
                    rises = 0;
                    check("load_low_at_done", load, 0);
                    check("busy_low_at_done", busy, 0);
                    if (exp_rx_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL done: got unexpected done pulse, expected none");
                    end else begin
                        check("rx_data", rx_data, exp_rx_q.pop_front());
                    end
                end
                sck_prev  = sck;
                load_prev = load;
            end
        end
    end

    task automatic push_frame(input logic [7:0] m1, input logic [7:0] m2, input logic [15:0] erx);
        logic [15:0] w;
        w = {m1, m2};
        for (int i = 15; i >= 0; i--) exp_bits.push_back(w[i]);
        exp_rx_q.push_back(erx);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(posedge clk); #1;
            seen = done;
        end
        check("done_within_bound", seen, 1);
    endtask

    task automatic run_frame(input logic [7:0] m1, input logic [7:0] m2,
                             input logic [15:0] erx, input logic [15:0] prev_rx);
        int d0;
        d0 = done_cnt;
        push_frame(m1, m2, erx);
        motor1 = m1;
        motor2 = m2;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("load_latency", load, 1);
        check("busy_in_frame", busy, 1);
        repeat (60) @(posedge clk);
        #1;
        check("rx_hold_mid_frame", rx_data, prev_rx);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
    endtask

    typedef struct {
        logic [7:0]  m1;
        logic [7:0]  m2;
        logic        loop;
        logic        sdi_val;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] prev;
        int          n;
        int          d0;

        vecs[0] = '{8'h99, 8'h32, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 16'hA53C};
        vecs[2] = '{8'h12, 8'hF0, 1'b0, 1'b1, 16'hFFFF};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, 1'b0, 16'h00FF};

        reset = 1'b1; start = 1'b0; motor1 = 8'h00; motor2 = 8'h00;
        sdi_val = 1'b0; loop = 1'b0; start1 = 1'b0; sdi1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sck", sck, 0);
        check("reset_sdo", sdo, 0);
        check("reset_load", load, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rx_data", rx_data, 16'h0000);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        prev = 16'h0000;
        foreach (vecs[i]) begin
            loop    = vecs[i].loop;
            sdi_val = vecs[i].sdi_val;
            run_frame(vecs[i].m1, vecs[i].m2, vecs[i].exp_rx, prev);
            prev = vecs[i].exp_rx;
        end

        // start re-pulsed and motors changed mid-frame must not disturb the frame.
        loop = 1'b1;
        d0 = done_cnt;
        push_frame(8'h99, 8'h32, 16'h9932);
        motor1 = 8'h99; motor2 = 8'h32; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10 || c == 40) begin
                start  = 1'b1;
                motor1 = 8'h6E;
                motor2 = 8'hC1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done();
        repeat (150) @(posedge clk);
        #1;
        check("no_restart_done_pulses", done_cnt - d0, 1);
        check("idle_after_ignored_start", busy, 0);

        // Reset at the 7th sck rise.
        loop = 1'b1;
        push_frame(8'hE7, 8'h18, 16'hE718);
        motor1 = 8'hE7; motor2 = 8'h18; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && rises < 7; c++) @(posedge clk);
        #1;
        check("reached_7th_rise", rises, 7);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("midreset_sck", sck, 0);
        check("midreset_sdo", sdo, 0);
        check("midreset_load", load, 0);
        check("midreset_busy", busy, 0);
        check("midreset_rx_data", rx_data, 16'h0000);
        exp_bits.delete();
        exp_rx_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midreset_no_done", done_cnt - d0, 0);
        run_frame(8'h5A, 8'hC3, 16'h5AC3, 16'h0000);

        // CLK_DIV=1, start held high, sdi tied 1 then 0.
        start1 = 1'b1;
        sdi1   = 1'b1;
        for (int c = 0; c < 10 && !load1; c++) begin
            @(posedge clk); #1;
        end
        n = 0;
        while (load1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("div1_load_high", n, 33);
        check("div1_done_in_gap", done1, 1);
        check("div1_busy_in_gap", busy1, 0);
        check("div1_rx_ones", rx_data1, 16'hFFFF);
        sdi1 = 1'b0;
        @(posedge clk); #1;
        check("div1_load_back_high", load1, 1);
        repeat (10) @(posedge clk);
        #1;
        check("div1_rx_hold", rx_data1, 16'hFFFF);
        n = 0;
        while (load1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("div1_done_second", done1, 1);
        check("div1_rx_zeros", rx_data1, 16'h0000);
        start1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/motor_spi_master.md
# motor_spi_master

Initiator end of the two-byte motor-command SPI link. It takes a parallel command (motor1, motor2, each sign bit plus 7-bit magnitude) and shifts it out on sck/sdo with the load frame that the FPGA-side command receiver expects. It also captures the 16 bits returned on sdi. It sits in the MCU-emulation/bring-up path and in the board-level loopback benches, clocked from the same divided oscillator domain as the motor controller.

## Interface

Parameters:
- CLK_DIV, 4, sck half-period in clk cycles; legal range 1..255.
- NBITS, 16, frame length in bits; fixed at 16 for this link.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset; returns the block to IDLE immediately.
- start  in  1  request a frame; sampled only in IDLE.
- motor1  in  8  first byte sent; [7] sign, [6:0] magnitude.
- motor2  in  8  second byte sent; same format.
- sdi  in  1  serial data from the receiver.
- sck  out  1  serial clock; idles low (mode 0).
- sdo  out  1  serial data to the receiver, MSB first.
- load  out  1  frame strobe; high for the whole frame.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse at frame end.
- rx_data  out  16  bits captured from sdi; first bit received is in [15].

## Operation

- All outputs are registered.
- Reset values: sck=0, sdo=0, load=0, busy=0, done=0, rx_data=16'h0000, state=IDLE, divider=0, bit count=0.
- State IDLE:
  - On start=1, latch tx_shift={motor1,motor2}, drive sdo=tx_shift[15] and load=1, set busy=1, then go to SETUP.
  - motor1 and motor2 are not sampled again during the frame.
- State SETUP: hold for CLK_DIV cycles. On the last cycle, set sck=1, shift sdi into rx_shift, then go to HIGH.
- State HIGH: hold for CLK_DIV cycles. On the last cycle, set sck=0. Then:
  - if fewer than 16 rising edges have been issued, shift tx_shift left, drive sdo with the new MSB, and go to LOW;
  - otherwise go to HOLD.
- State LOW: hold for CLK_DIV cycles. On the last cycle, set sck=1, shift sdi into rx_shift, then go to HIGH.
- State HOLD: hold for CLK_DIV cycles with sck=0 and sdo stable. On the last cycle:
  - set load=0, busy=0, done=1 for one cycle, sdo=0;
  - set rx_data=rx_shift;
  - go to IDLE.
- sdi sampling: sdi is sampled on the clk edge that drives sck high, i.e. the value present just before the rising sck edge.
- sdo changes only while sck is low, or at frame start; it never changes on the edge that raises sck.
- start while busy=1 is ignored and is not queued.
- start in the same cycle that done=1 is accepted, because the block is already in IDLE; this gives back-to-back frames.
- rx_data updates only at frame end. It holds its value through IDLE and through the next frame until that frame completes.
- Reset mid-frame: all outputs go to their reset values asynchronously. load falls without a done pulse, and the partial rx_shift is discarded.

## Timing

- Latency from start to load high: 1 clk.
- load stays high for 33*CLK_DIV clk cycles: SETUP 1 + HIGH 16 + LOW 15 + HOLD 1 phases, each CLK_DIV cycles.
- With CLK_DIV=4, load is high for 132 clk cycles.
- From load rising to the first sck rise: CLK_DIV cycles.
- From the last sck fall to load falling: CLK_DIV cycles.
- Exactly 16 sck rising edges per frame; sck period is 2*CLK_DIV.
- done asserts in the first clk cycle after load falls. busy is already 0 in that same cycle.
- Minimum frame-to-frame spacing, start tied high: 33*CLK_DIV+1 cycles between load rises.

## Test plan

- Single frame, CLK_DIV=4, motor1=8'h99, motor2=8'h32:
  - sdo sampled at each sck rise reads 1001_1001_0011_0010;
  - exactly 16 sck rises;
  - load high for 132 cycles;
  - one done pulse.
- Loopback sdo->sdi, motor1=8'hA5, motor2=8'h3C: rx_data=16'hA53C after done; rx_data unchanged until the next done.
- start pulsed at cycles 10 and 40 of a frame: no restart, sdo sequence unchanged, one done. motor1/motor2 changed mid-frame: no effect on sdo.
- reset asserted at the 7th sck rise: sck/sdo/load/busy go to 0 immediately, no done, rx_data=0. A new start after reset deasserts produces a correct full frame.
- CLK_DIV=1, start held high, sdi tied 1:
  - load high for 33 cycles, low for exactly 1 cycle, then high again;
  - done=1 in that low cycle;
  - rx_data=16'hFFFF.
- sdi tied 0 after a frame with sdi tied 1: rx_data goes from 16'hFFFF to 16'h0000 only at the second done.
